// File: rtl/rom_dl_sequencer.sv
// rtl/rom_dl_sequencer.sv - routes HPS ROM download bytes to SDRAM ports, sound BRAM and PROM
module rom_dl_sequencer #(
    parameter logic [23:0] P2_BASE    = 24'h30000,
    parameter logic [23:0] SND_BASE   = 24'h20000,
    parameter logic [23:0] SND_END    = 24'h30000,
    parameter logic [23:0] PROM_BASE  = 24'hA0000,
    parameter logic [15:0] RESET_HOLD = 16'hFFFF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    input  logic        user_reset,
    output logic        p1_req,
    input  logic        p1_ack,
    output logic [22:0] p1_a,
    output logic [1:0]  p1_ds,
    output logic        p2_req,
    input  logic        p2_ack,
    output logic [22:0] p2_a,
    output logic [1:0]  p2_ds,
    output logic [15:0] wr_d,
    output logic        snd_we,
    output logic [15:0] snd_a,
    output logic        prom_we,
    output logic [11:0] prom_a,
    output logic        rom_loaded,
    output logic        core_reset,
    output logic        overrun
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        p1_req_q, p1_req_d;
    logic        p2_req_q, p2_req_d;
    logic        snd_we_q, snd_we_d;
    logic        prom_we_q, prom_we_d;
    logic        overrun_q, overrun_d;
    logic        rom_loaded_q, rom_loaded_d;
    logic        dl_q, dl_d;
    logic        dl_idx0_q, dl_idx0_d;
    logic        done_pend_q, done_pend_d;
    logic [15:0] cnt_q, cnt_d;
    logic        core_reset_q, core_reset_d;

    logic        acc;
    logic        in_prom;
    logic        in_p2;
    logic        in_snd;
    logic        pending;
    logic        dl_fall;
    logic [23:0] p2_off;
    logic [11:0] prom_off;

    always_comb begin
        acc     = ioctl_download & (ioctl_index == 8'd0) & ioctl_wr;
        // 25-bit compares so addresses at or above 2^24 land in the PROM region
        in_prom = ioctl_addr >= {1'b0, PROM_BASE};
        in_p2   = ioctl_addr >= {1'b0, P2_BASE};
        in_snd  = (ioctl_addr >= {1'b0, SND_BASE}) && (ioctl_addr < {1'b0, SND_END});
        pending = (p1_req_q != p1_ack) | (p2_req_q != p2_ack);
        dl_fall = dl_q & ~ioctl_download & dl_idx0_q;

        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        p1_req_d     = p1_req_q;
        p2_req_d     = p2_req_q;
        snd_we_d     = 1'b0;
        prom_we_d    = 1'b0;
        overrun_d    = overrun_q;
        rom_loaded_d = rom_loaded_q;
        done_pend_d  = done_pend_q;
        dl_d         = ioctl_download;
        dl_idx0_d    = ioctl_download ? (ioctl_index == 8'd0) : dl_idx0_q;

        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    addr_d   = ioctl_addr[23:0];
                    data_d   = ioctl_dout;
                    snd_we_d = in_snd;
                    if (in_prom) begin
                        prom_we_d = 1'b1;
                    end else begin
                        p1_req_d = ~p1_req_q;
                        if (in_p2) begin
                            p2_req_d = ~p2_req_q;
                        end
                        state_d = S_WAIT;
                    end
                end
            end
            default: begin
                if (acc) begin
                    overrun_d = 1'b1;
                end
                if (!pending) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        // A download that ends mid-write completes only once the last write is acked
        if ((dl_fall | done_pend_q) && (state_q == S_IDLE)) begin
            rom_loaded_d = 1'b1;
            done_pend_d  = 1'b0;
        end else if (dl_fall) begin
            done_pend_d = 1'b1;
        end

        cnt_d = cnt_q;
        if (user_reset | ~rom_loaded_q | ioctl_download) begin
            cnt_d = RESET_HOLD;
        end else if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end
        core_reset_d = (cnt_q != 16'd0);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= 24'd0;
            data_q       <= 8'd0;
            p1_req_q     <= p1_ack;
            p2_req_q     <= p2_ack;
            snd_we_q     <= 1'b0;
            prom_we_q    <= 1'b0;
            overrun_q    <= 1'b0;
            rom_loaded_q <= 1'b0;
            dl_q         <= 1'b0;
            dl_idx0_q    <= 1'b0;
            done_pend_q  <= 1'b0;
            cnt_q        <= RESET_HOLD;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            p1_req_q     <= p1_req_d;
            p2_req_q     <= p2_req_d;
            snd_we_q     <= snd_we_d;
            prom_we_q    <= prom_we_d;
            overrun_q    <= overrun_d;
            rom_loaded_q <= rom_loaded_d;
            dl_q         <= dl_d;
            dl_idx0_q    <= dl_idx0_d;
            done_pend_q  <= done_pend_d;
            cnt_q        <= cnt_d;
            core_reset_q <= core_reset_d;
        end
    end

    always_comb begin
        p2_off   = addr_q - P2_BASE;
        prom_off = addr_q[11:0] - PROM_BASE[11:0];
    end

    assign ioctl_wait = (state_q == S_WAIT);
    assign p1_req     = p1_req_q;
    assign p2_req     = p2_req_q;
    assign p1_a       = addr_q[23:1];
    assign p1_ds      = {addr_q[0], ~addr_q[0]};
    assign p2_a       = p2_off[23:1];
    assign p2_ds      = {p2_off[0], ~p2_off[0]};
    assign wr_d       = {data_q, data_q};
    assign snd_we     = snd_we_q;
    assign snd_a      = addr_q[15:0];
    assign prom_we    = prom_we_q;
    assign prom_a     = prom_off;
    assign rom_loaded = rom_loaded_q;
    assign core_reset = core_reset_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// tb/tb_rom_dl_sequencer.sv - directed self-checking bench for rom_dl_sequencer
module tb_rom_dl_sequencer;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic        ioctl_wait;
    logic        user_reset = 1'b0;
    logic        p1_req;
    logic        p1_ack = 1'b0;
    logic [22:0] p1_a;
    logic [1:0]  p1_ds;
    logic        p2_req;
    logic        p2_ack = 1'b0;
    logic [22:0] p2_a;
    logic [1:0]  p2_ds;
    logic [15:0] wr_d;
    logic        snd_we;
    logic [15:0] snd_a;
    logic        prom_we;
    logic [11:0] prom_a;
    logic        rom_loaded;
    logic        core_reset;
    logic        overrun;

    int checks = 0;
    int failures = 0;
    logic exp_p1 = 1'b0;
    logic exp_p2 = 1'b0;

    rom_dl_sequencer #(.RESET_HOLD(16'd16)) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .user_reset(user_reset),
        .p1_req(p1_req), .p1_ack(p1_ack), .p1_a(p1_a), .p1_ds(p1_ds),
        .p2_req(p2_req), .p2_ack(p2_ack), .p2_a(p2_a), .p2_ds(p2_ds),
        .wr_d(wr_d), .snd_we(snd_we), .snd_a(snd_a), .prom_we(prom_we),
        .prom_a(prom_a), .rom_loaded(rom_loaded), .core_reset(core_reset),
        .overrun(overrun)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        step();
        ioctl_wr   = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        p1_ack = 1'b0;
        p2_ack = 1'b1;
        repeat (3) step();
        reset  = 1'b0;
        exp_p1 = 1'b0;
        exp_p2 = 1'b1;
        checks++; if (ioctl_wait !== 1'b0) begin failures++; $display("FAIL reset_wait: got %b exp 0", ioctl_wait); end
        checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL reset_core_reset: got %b exp 1", core_reset); end
        checks++; if (rom_loaded !== 1'b0) begin failures++; $display("FAIL reset_rom_loaded: got %b exp 0", rom_loaded); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b exp 0", overrun); end
        checks++; if ({snd_we, prom_we} !== 2'b00) begin failures++; $display("FAIL reset_strobes: got %b exp 00", {snd_we, prom_we}); end
        checks++; if ({p1_req, p2_req} !== 2'b01) begin failures++; $display("FAIL reset_reqs: got %b exp 01", {p1_req, p2_req}); end
        checks++; if (wr_d !== 16'h0000) begin failures++; $display("FAIL reset_wr_d: got %h exp 0000", wr_d); end
    endtask

    task automatic test_p1_write();
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        step();
        send_byte(25'h00001, 8'hA5);
        exp_p1 = ~exp_p1;
        checks++; if (p1_req !== exp_p1) begin failures++; $display("FAIL p1_req_toggle: got %b exp %b", p1_req, exp_p1); end
        checks++; if (p2_req !== exp_p2) begin failures++; $display("FAIL p1_p2_unchanged: got %b exp %b", p2_req, exp_p2); end
        checks++; if (p1_a !== 23'h0) begin failures++; $display("FAIL p1_a: got %h exp 0", p1_a); end
        checks++; if (p1_ds !== 2'b10) begin failures++; $display("FAIL p1_ds: got %b exp 10", p1_ds); end
        checks++; if (wr_d !== 16'hA5A5) begin failures++; $display("FAIL p1_wr_d: got %h exp a5a5", wr_d); end
        checks++; if (ioctl_wait !== 1'b1) begin failures++; $display("FAIL p1_wait_rise: got %b exp 1", ioctl_wait); end
        step();
        step();
        p1_ack = ~p1_ack;
        checks++; if (ioctl_wait !== 1'b1) begin failures++; $display("FAIL p1_wait_hold: got %b exp 1", ioctl_wait); end
        checks++; if ({p1_a, p1_ds} !== {23'h0, 2'b10}) begin failures++; $display("FAIL p1_stable: got %h exp 2", {p1_a, p1_ds}); end
        step();
        checks++; if (ioctl_wait !== 1'b0) begin failures++; $display("FAIL p1_wait_fall: got %b exp 0", ioctl_wait); end
    endtask

    task automatic test_p2_write();
        send_byte(25'h30004, 8'h3C);
        exp_p1 = ~exp_p1;
        exp_p2 = ~exp_p2;
        checks++; if ({p1_req, p2_req} !== {exp_p1, exp_p2}) begin failures++; $display("FAIL p2_reqs: got %b exp %b", {p1_req, p2_req}, {exp_p1, exp_p2}); end
        checks++; if (p2_a !== 23'h2) begin failures++; $display("FAIL p2_a: got %h exp 2", p2_a); end
        checks++; if (p2_ds !== 2'b01) begin failures++; $display("FAIL p2_ds: got %b exp 01", p2_ds); end
        checks++; if (p1_a !== 23'h18002) begin failures++; $display("FAIL p2_p1_a: got %h exp 18002", p1_a); end
        checks++; if (wr_d !== 16'h3C3C) begin failures++; $display("FAIL p2_wr_d: got %h exp 3c3c", wr_d); end
        step();
        p1_ack = ~p1_ack;
        step();
        step();
        checks++; if (ioctl_wait !== 1'b1) begin failures++; $display("FAIL p2_wait_p1_only: got %b exp 1", ioctl_wait); end
        step();
        p2_ack = ~p2_ack;
        checks++; if (ioctl_wait !== 1'b1) begin failures++; $display("FAIL p2_wait_hold: got %b exp 1", ioctl_wait); end
        step();
        checks++; if (ioctl_wait !== 1'b0) begin failures++; $display("FAIL p2_wait_fall: got %b exp 0", ioctl_wait); end
    endtask

    task automatic test_snd();
        send_byte(25'h2ABCD, 8'h11);
        exp_p1 = ~exp_p1;
        checks++; if (snd_we !== 1'b1) begin failures++; $display("FAIL snd_we_pulse: got %b exp 1", snd_we); end
        checks++; if (snd_a !== 16'hABCD) begin failures++; $display("FAIL snd_a: got %h exp abcd", snd_a); end
        checks++; if ({p1_req, p2_req} !== {exp_p1, exp_p2}) begin failures++; $display("FAIL snd_reqs: got %b exp %b", {p1_req, p2_req}, {exp_p1, exp_p2}); end
        checks++; if (prom_we !== 1'b0) begin failures++; $display("FAIL snd_prom_we: got %b exp 0", prom_we); end
        step();
        checks++; if (snd_we !== 1'b0) begin failures++; $display("FAIL snd_we_end: got %b exp 0", snd_we); end
        p1_ack = ~p1_ack;
        step();
        checks++; if (ioctl_wait !== 1'b0) begin failures++; $display("FAIL snd_wait_fall: got %b exp 0", ioctl_wait); end
    endtask

    task automatic test_prom();
        send_byte(25'hA0305, 8'h7E);
        checks++; if (prom_we !== 1'b1) begin failures++; $display("FAIL prom_we_pulse: got %b exp 1", prom_we); end
        checks++; if (prom_a !== 12'h305) begin failures++; $display("FAIL prom_a: got %h exp 305", prom_a); end
        checks++; if (ioctl_wait !== 1'b0) begin failures++; $display("FAIL prom_wait: got %b exp 0", ioctl_wait); end
        checks++; if ({p1_req, p2_req} !== {exp_p1, exp_p2}) begin failures++; $display("FAIL prom_reqs: got %b exp %b", {p1_req, p2_req}, {exp_p1, exp_p2}); end
        checks++; if (snd_we !== 1'b0) begin failures++; $display("FAIL prom_snd_we: got %b exp 0", snd_we); end
        step();
        checks++; if ({prom_we, ioctl_wait} !== 2'b00) begin failures++; $display("FAIL prom_end: got %b exp 00", {prom_we, ioctl_wait}); end
    endtask

    task automatic test_boundaries();
        send_byte(25'h2FFFF, 8'h01);
        exp_p1 = ~exp_p1;
        checks++; if ({snd_we, p1_req, p2_req} !== {1'b1, exp_p1, exp_p2}) begin failures++; $display("FAIL bnd_snd_last: got %b exp %b", {snd_we, p1_req, p2_req}, {1'b1, exp_p1, exp_p2}); end
        p1_ack = ~p1_ack;
        step();
        send_byte(25'h30000, 8'h02);
        exp_p1 = ~exp_p1;
        exp_p2 = ~exp_p2;
        checks++; if ({snd_we, p1_req, p2_req} !== {1'b0, exp_p1, exp_p2}) begin failures++; $display("FAIL bnd_p2_first: got %b exp %b", {snd_we, p1_req, p2_req}, {1'b0, exp_p1, exp_p2}); end
        checks++; if ({p2_a, p2_ds} !== {23'h0, 2'b01}) begin failures++; $display("FAIL bnd_p2_first_a: got %h exp 1", {p2_a, p2_ds}); end
        p1_ack = ~p1_ack;
        p2_ack = ~p2_ack;
        step();
        send_byte(25'h9FFFF, 8'h03);
        exp_p1 = ~exp_p1;
        exp_p2 = ~exp_p2;
        checks++; if ({prom_we, p1_req, p2_req} !== {1'b0, exp_p1, exp_p2}) begin failures++; $display("FAIL bnd_p2_last: got %b exp %b", {prom_we, p1_req, p2_req}, {1'b0, exp_p1, exp_p2}); end
        checks++; if ({p2_a, p2_ds} !== {23'h37FFF, 2'b10}) begin failures++; $display("FAIL bnd_p2_last_a: got %h exp %h", {p2_a, p2_ds}, {23'h37FFF, 2'b10}); end
        p1_ack = ~p1_ack;
        p2_ack = ~p2_ack;
        step();
        checks++; if (ioctl_wait !== 1'b0) begin failures++; $display("FAIL bnd_idle: got %b exp 0", ioctl_wait); end
        send_byte(25'h1000000, 8'h04);
        checks++; if ({prom_we, ioctl_wait, p1_req, p2_req} !== {2'b10, exp_p1, exp_p2}) begin failures++; $display("FAIL bnd_high_prom: got %b exp %b", {prom_we, ioctl_wait, p1_req, p2_req}, {2'b10, exp_p1, exp_p2}); end
        checks++; if (prom_a !== 12'h000) begin failures++; $display("FAIL bnd_high_prom_a: got %h exp 000", prom_a); end
        step();
    endtask

    task automatic test_overrun_complete();
        send_byte(25'h00010, 8'h55);
        exp_p1 = ~exp_p1;
        step();
        send_byte(25'h00020, 8'h99);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag: got %b exp 1", overrun); end
        checks++; if (p1_req !== exp_p1) begin failures++; $display("FAIL ovr_no_toggle: got %b exp %b", p1_req, exp_p1); end
        checks++; if ({p1_a, wr_d} !== {23'h8, 16'h5555}) begin failures++; $display("FAIL ovr_stable: got %h exp %h", {p1_a, wr_d}, {23'h8, 16'h5555}); end
        ioctl_download = 1'b0;
        step();
        step();
        checks++; if ({rom_loaded, ioctl_wait} !== 2'b01) begin failures++; $display("FAIL cmp_deferred: got %b exp 01", {rom_loaded, ioctl_wait}); end
        p1_ack = ~p1_ack;
        step();
        checks++; if ({rom_loaded, ioctl_wait} !== 2'b00) begin failures++; $display("FAIL cmp_ack_edge: got %b exp 00", {rom_loaded, ioctl_wait}); end
        step();
        checks++; if ({rom_loaded, core_reset} !== 2'b11) begin failures++; $display("FAIL cmp_loaded: got %b exp 11", {rom_loaded, core_reset}); end
        repeat (16) step();
        checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL stretch_hold: got %b exp 1", core_reset); end
        step();
        checks++; if (core_reset !== 1'b0) begin failures++; $display("FAIL stretch_release: got %b exp 0", core_reset); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %b exp 1", overrun); end
    endtask

    task automatic test_reset_mid_wait();
        ioctl_download = 1'b1;
        step();
        send_byte(25'h00040, 8'h66);
        exp_p1 = ~exp_p1;
        checks++; if ({ioctl_wait, p1_req} !== {1'b1, exp_p1}) begin failures++; $display("FAIL rmw_issue: got %b exp %b", {ioctl_wait, p1_req}, {1'b1, exp_p1}); end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_p1 = p1_ack;
        checks++; if (ioctl_wait !== 1'b0) begin failures++; $display("FAIL rmw_wait: got %b exp 0", ioctl_wait); end
        checks++; if (p1_req !== exp_p1) begin failures++; $display("FAIL rmw_req_ack: got %b exp %b", p1_req, exp_p1); end
        checks++; if ({rom_loaded, core_reset, overrun} !== 3'b010) begin failures++; $display("FAIL rmw_flags: got %b exp 010", {rom_loaded, core_reset, overrun}); end
        step();
        checks++; if (ioctl_wait !== 1'b0) begin failures++; $display("FAIL rmw_idle: got %b exp 0", ioctl_wait); end
    endtask

    task automatic test_index1();
        ioctl_index = 8'd1;
        step();
        send_byte(25'h00100, 8'hAA);
        checks++; if ({snd_we, prom_we, ioctl_wait, p1_req, p2_req} !== {3'b000, exp_p1, exp_p2}) begin failures++; $display("FAIL idx1_p1: got %b exp %b", {snd_we, prom_we, ioctl_wait, p1_req, p2_req}, {3'b000, exp_p1, exp_p2}); end
        send_byte(25'h2ABCD, 8'hBB);
        checks++; if ({snd_we, prom_we, ioctl_wait, p1_req, p2_req} !== {3'b000, exp_p1, exp_p2}) begin failures++; $display("FAIL idx1_snd: got %b exp %b", {snd_we, prom_we, ioctl_wait, p1_req, p2_req}, {3'b000, exp_p1, exp_p2}); end
        send_byte(25'hA0001, 8'hCC);
        checks++; if ({snd_we, prom_we, ioctl_wait, p1_req, p2_req} !== {3'b000, exp_p1, exp_p2}) begin failures++; $display("FAIL idx1_prom: got %b exp %b", {snd_we, prom_we, ioctl_wait, p1_req, p2_req}, {3'b000, exp_p1, exp_p2}); end
        ioctl_download = 1'b0;
        repeat (3) step();
        checks++; if ({rom_loaded, core_reset} !== 2'b01) begin failures++; $display("FAIL idx1_no_complete: got %b exp 01", {rom_loaded, core_reset}); end
    endtask

    initial begin
        test_reset();
        test_p1_write();
        test_p2_write();
        test_snd();
        test_prom();
        test_boundaries();
        test_overrun_complete();
        test_reset_mid_wait();
        test_index1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_dl_sequencer.md
Name: rom_dl_sequencer

Overview:
- Sequences the HPS ROM download stream (index 0) into the game's storage.
- Decodes each ioctl byte address and issues toggle-handshake write requests to the SDRAM CPU port (port1) and sprite/tile port (port2).
- Generates the sound-ROM BRAM write strobe and the PROM download strobe.
- Throttles the HPS via ioctl_wait; owns rom_loaded and the core reset stretcher. Sits between hps_io and the sdram / target_top blocks.

Parameters:
- P2_BASE, 24'h30000, first byte address routed to port2; port2 address = addr - P2_BASE.
- SND_BASE, 24'h20000, first byte of sound ROM region.
- SND_END, 24'h30000, first byte past sound ROM region.
- PROM_BASE, 24'hA0000, first byte of PROM region; this region is not sent to SDRAM.
- RESET_HOLD, 16'hFFFF, core reset stretch in clk_sys cycles.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous active-high reset
- ioctl_download  in  1  download active from hps_io
- ioctl_index  in  8  download index; only 0 is handled
- ioctl_wr  in  1  byte write strobe, one cycle
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- ioctl_wait  out  1  HPS hold-off while an SDRAM write is pending
- user_reset  in  1  status[0] | buttons[1]
- p1_req  out  1  port1 request toggle
- p1_ack  in  1  port1 ack toggle
- p1_a  out  23  port1 word address (addr[23:1])
- p1_ds  out  2  byte enables {addr[0], ~addr[0]}
- p2_req  out  1  port2 request toggle
- p2_ack  in  1  port2 ack toggle
- p2_a  out  23  port2 word address ((addr - P2_BASE)[23:1])
- p2_ds  out  2  port2 byte enables
- wr_d  out  16  {byte, byte}, shared by both ports
- snd_we  out  1  sound BRAM write strobe
- snd_a  out  16  sound BRAM address (addr[15:0])
- prom_we  out  1  PROM write strobe
- prom_a  out  12  addr - PROM_BASE (low 12 bits)
- rom_loaded  out  1  sticky: at least one download has completed
- core_reset  out  1  reset to target_top
- overrun  out  1  sticky: ioctl_wr arrived while busy

Behaviour:
- Reset values:
  - ioctl_wait, snd_we, prom_we, overrun, rom_loaded = 0; core_reset = 1.
  - p1_req <= p1_ack and p2_req <= p2_ack, so no request is pending after reset.
  - Address and data registers = 0; FSM = IDLE.
- Accept condition: acc = ioctl_download & (ioctl_index==0) & ioctl_wr, evaluated in IDLE only.
- On acc, latch addr and data on the same edge, then route:
  - addr < PROM_BASE: toggle p1_req.
  - P2_BASE <= addr < PROM_BASE: also toggle p2_req.
  - SND_BASE <= addr < SND_END: pulse snd_we for exactly one cycle, the cycle after acc.
  - addr >= PROM_BASE: pulse prom_we one cycle; no SDRAM request; FSM stays IDLE.
- FSM states:
  - IDLE -> WAIT on acc with any SDRAM request issued; ioctl_wait rises the cycle after acc.
  - WAIT: hold while (p1_req!=p1_ack) | (p2_req!=p2_ack). When both match -> IDLE; ioctl_wait falls the same edge.
  - ioctl_wait = (state==WAIT).
- p1_a/p2_a/ds/wr_d stay stable from the issue edge until the ack completes.
- acc seen in WAIT: the byte is dropped, overrun is set (cleared only by reset), and no request toggles.
- Completion:
  - Track the download falling edge (index 0 only). If it falls in WAIT, completion is deferred until the FSM returns to IDLE.
  - At completion, rom_loaded <= 1.
- Reset stretcher:
  - cnt <= RESET_HOLD while user_reset | ~rom_loaded | download active; otherwise decrement to 0.
  - core_reset = (cnt != 0), registered.
- Non-zero ioctl_index is ignored entirely: no strobes, no requests, rom_loaded unaffected.
- Address arithmetic is unsigned 25-bit; values >= 2^24 are treated as PROM region.

Test Plan:
- Reset, then a byte at addr 0x00001 = 0xA5.
  - p1_req toggles, p1_a = 0, p1_ds = 2'b10, wr_d = 0xA5A5, p2_req unchanged.
  - ioctl_wait stays high until p1_ack toggles 3 cycles later, falls that edge.
- Byte at 0x30004 = 0x3C: both reqs toggle, p2_a = 2, p2_ds = 2'b01; wait clears only when both acks have returned (p2 ack delayed 5 cycles vs p1 2).
- Byte at 0x2ABCD: snd_we high exactly one cycle with snd_a = 0xABCD, and p1_req also toggles.
- Byte at 0xA0305 = 0x7E: prom_we one cycle with prom_a = 0x305; no req toggles; ioctl_wait stays 0.
- Second ioctl_wr during WAIT: overrun = 1, no extra toggle. Download drops during WAIT: rom_loaded rises only after ack; core_reset falls RESET_HOLD+1 cycles later (test with RESET_HOLD = 16).
- Reset asserted mid-WAIT with ack still pending: FSM returns to IDLE, p1_req == p1_ack, ioctl_wait = 0. Index 1 writes produce no outputs.
